// File: rtl/npc_pkg.sv
// Shared definitions for the multicycle sequencer: state encoding,
// write-back select codes and RV32 opcode constants.
package npc_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_IF_REQ   = 3'd1,
      S_IF_WAIT  = 3'd2,
      S_EXEC     = 3'd3,
      S_MEM_REQ  = 3'd4,
      S_MEM_WAIT = 3'd5,
      S_WB       = 3'd6,
      S_HALT     = 3'd7
   } state_t;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_PC4 = 2'd1;
   localparam logic [1:0] WB_MEM = 2'd2;
   localparam logic [1:0] WB_IMM = 2'd3;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

   // A load writes back from memory; a store writes memory.
   function automatic logic is_mem_op(input logic [1:0] wbsel, input logic dmwen);
      return (wbsel == WB_MEM) || dmwen;
   endfunction

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter; wraps from 0xFFFFFFFF to 0.
module instret_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] count
);

   // count one per retire strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 32'd0;
      end else if (inc) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: fetch, execute, optional memory
// access and write-back over one shared memory port.
// Optional build macro: MISALIGN_CHECK_EN adds the pc_lo port and halts on
// a misaligned fetch or a misaligned load/store address.
//
// state      | meaning
// -----------+---------------------------------------------------
// IDLE       | one cycle after reset, then fetch
// IF_REQ     | instruction fetch request, held until mem_gnt
// IF_WAIT    | waiting for fetch data, latch ir on mem_rvalid
// EXEC       | one-cycle decode/execute, choose next step
// MEM_REQ    | load/store request at ALU address, held until mem_gnt
// MEM_WAIT   | waiting for load data, latch mdr on mem_rvalid
// WB         | one cycle: PC update, register write, retire
// HALT       | absorbing; left only through rst
module multicycle_sequencer
   import npc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ir,
   output logic [31:0] mdr,
   input  logic        ctrl_regwen,
   input  logic        ctrl_dmwen,
   input  logic [1:0]  ctrl_wbsel,
   input  logic        halt_req,
   input  logic [1:0]  alu_lo,
`ifdef MISALIGN_CHECK_EN
   input  logic [1:0]  pc_lo,
`endif
   output logic        pc_we,
   output logic        reg_we,
   output logic [2:0]  state,
   output logic        halted,
   output logic [31:0] instret
);

   state_t state_q;
   state_t state_nxt;
   logic   mem_req_q;
   logic   misalign_mem;
   logic   misalign_pc;

`ifdef MISALIGN_CHECK_EN
   assign misalign_mem = (alu_lo != 2'b00);
   assign misalign_pc  = (state_q == S_IF_REQ) && (pc_lo != 2'b00);
`else
   logic unused_alu_lo;
   assign unused_alu_lo = ^alu_lo;
   assign misalign_mem  = 1'b0;
   assign misalign_pc   = 1'b0;
`endif

   // next-state selection; rvalid only matters in the WAIT states, gnt only in the REQ states
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:     state_nxt = S_IF_REQ;
         S_IF_REQ: begin
            if (misalign_pc)  state_nxt = S_HALT;
            else if (mem_gnt) state_nxt = S_IF_WAIT;
         end
         S_IF_WAIT: begin
            if (mem_rvalid) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (halt_req)                              state_nxt = S_HALT;
            else if (is_mem_op(ctrl_wbsel, ctrl_dmwen)) state_nxt = misalign_mem ? S_HALT : S_MEM_REQ;
            else                                       state_nxt = S_WB;
         end
         S_MEM_REQ: begin
            if (mem_gnt) state_nxt = ctrl_dmwen ? S_WB : S_MEM_WAIT;
         end
         S_MEM_WAIT: begin
            if (mem_rvalid) state_nxt = S_WB;
         end
         S_WB:       state_nxt = S_IF_REQ;
         S_HALT:     state_nxt = S_HALT;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // state register, data latches and strobes registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ir           <= 32'd0;
         mdr          <= 32'd0;
         mem_req_q    <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr_sel <= 1'b0;
         pc_we        <= 1'b0;
         reg_we       <= 1'b0;
         halted       <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         mem_req_q    <= (state_nxt == S_IF_REQ) || (state_nxt == S_MEM_REQ);
         mem_addr_sel <= (state_nxt == S_MEM_REQ);
         mem_we       <= (state_nxt == S_MEM_REQ) && ctrl_dmwen;
         pc_we        <= (state_nxt == S_WB);
         reg_we       <= (state_nxt == S_WB) && ctrl_regwen;
         halted       <= (state_nxt == S_HALT);
         if ((state_q == S_IF_WAIT) && mem_rvalid) ir <= mem_rdata;
         if ((state_q == S_MEM_WAIT) && mem_rvalid) mdr <= mem_rdata;
      end
   end

   // a misaligned fetch is suppressed in the very cycle it is detected
   assign mem_req = mem_req_q & ~misalign_pc;
   assign state   = state_q;

   instret_counter u_instret (
      .clk   (clk),
      .rst   (rst),
      .inc   (pc_we),
      .count (instret)
   );

endmodule

// File: tb/tb_multicycle_sequencer.sv
`timescale 1ns/1ps
module tb_multicycle_sequencer;
   import npc_pkg::*;

   localparam int K_ALU   = 0;
   localparam int K_LOAD  = 1;
   localparam int K_STORE = 2;
   localparam int K_HALT  = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req, mem_we, mem_addr_sel;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] ir, mdr, instret;
   logic        ctrl_regwen, ctrl_dmwen, halt_req;
   logic [1:0]  ctrl_wbsel, alu_lo;
   logic        pc_we, reg_we, halted;
   logic [2:0]  state;
`ifdef MISALIGN_CHECK_EN
   logic [1:0]  pc_lo;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_instret;
   logic [31:0] exp_mdr;
   logic [5:0]  outs;

   assign outs = {mem_req, mem_addr_sel, mem_we, pc_we, reg_we, halted};

   multicycle_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .mem_gnt      (mem_gnt),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .ir           (ir),
      .mdr          (mdr),
      .ctrl_regwen  (ctrl_regwen),
      .ctrl_dmwen   (ctrl_dmwen),
      .ctrl_wbsel   (ctrl_wbsel),
      .halt_req     (halt_req),
      .alu_lo       (alu_lo),
`ifdef MISALIGN_CHECK_EN
      .pc_lo        (pc_lo),
`endif
      .pc_we        (pc_we),
      .reg_we       (reg_we),
      .state        (state),
      .halted       (halted),
      .instret      (instret)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // {mem_req, mem_addr_sel, mem_we, pc_we, reg_we, halted}
   task automatic chk_outs(input string tag, input logic req, input logic sel, input logic we,
                           input logic pcw, input logic rgw, input logic hlt);
      chk(tag, {26'd0, outs}, {26'd0, req, sel, we, pcw, rgw, hlt});
   endtask

   task automatic chk_state(input string tag, input state_t s);
      chk(tag, {29'd0, state}, 32'(s));
   endtask

   function automatic logic [31:0] make_instr(input int kind);
      logic [31:0] r;
      r = $urandom();
      case (kind)
         K_ALU:   return {r[31:7], OPC_OP_IMM};
         K_LOAD:  return {r[31:15], 3'b010, r[11:7], OPC_LOAD};
         K_STORE: return {r[31:15], 3'b010, r[11:7], OPC_STORE};
         default: return INSN_EBREAK;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      ctrl_regwen = 1'b0; ctrl_dmwen = 1'b0; ctrl_wbsel = WB_ALU;
      halt_req = 1'b0; alu_lo = 2'b00;
`ifdef MISALIGN_CHECK_EN
      pc_lo = 2'b00;
`endif
      step();
      chk_outs("rst_strobes", 0, 0, 0, 0, 0, 0);
      step();
      rst = 1'b0;
      exp_instret = 32'd0;
      exp_mdr = 32'd0;
      chk_state("rst_state", S_IDLE);
      chk("rst_ir", ir, 32'd0);
      chk("rst_mdr", mdr, 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk_outs("idle_strobes", 0, 0, 0, 0, 0, 0);
   endtask

   // One instruction, entered with the DUT in IF_REQ. Memory timing:
   // gnt after gf/gd extra request cycles, rvalid rf/rd (>=1) cycles after gnt.
   task automatic run_instr(input int kind, input int gf, input int rf, input int gd, input int rd,
                            input logic [31:0] ddata, input logic [1:0] alo, input int rw);
      logic [31:0] fdata;
      logic        regwen;
      logic        misal;
      logic        is_st;
      fdata = make_instr(kind);
      is_st = (kind == K_STORE);
      for (int i = 0; i <= gf; i++) begin
         chk_outs("if_req", 1, 0, 0, 0, 0, 0);
         mem_gnt    = (i == gf);
         mem_rvalid = 1'($urandom_range(0, 1));
         mem_rdata  = $urandom();
         step();
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      for (int i = 1; i <= rf; i++) begin
         chk_outs("if_wait", 0, 0, 0, 0, 0, 0);
         mem_rvalid = (i == rf);
         mem_rdata  = (i == rf) ? fdata : $urandom();
         step();
      end
      mem_rvalid = 1'b0;
      chk("ir", ir, fdata);
      chk_state("exec_state", S_EXEC);
      chk_outs("exec", 0, 0, 0, 0, 0, 0);
      regwen = (rw == 2) ? 1'($urandom_range(0, 1)) : rw[0];
      case (kind)
         K_ALU: begin
            ctrl_regwen = regwen; ctrl_dmwen = 1'b0;
            ctrl_wbsel = ($urandom_range(0, 1) == 0) ? WB_ALU : WB_IMM;
         end
         K_LOAD:  begin regwen = 1'b1; ctrl_regwen = 1'b1; ctrl_dmwen = 1'b0; ctrl_wbsel = WB_MEM; end
         K_STORE: begin regwen = 1'b0; ctrl_regwen = 1'b0; ctrl_dmwen = 1'b1; ctrl_wbsel = WB_PC4; end
         default: begin regwen = 1'b0; ctrl_regwen = 1'b0; ctrl_dmwen = 1'b0; ctrl_wbsel = WB_ALU; end
      endcase
      halt_req = (kind == K_HALT);
      alu_lo = alo;
`ifdef MISALIGN_CHECK_EN
      misal = (kind == K_LOAD || kind == K_STORE) && (alo != 2'b00);
`else
      misal = 1'b0;
`endif
      step();
      if (kind == K_HALT || misal) begin
         for (int i = 0; i < 20; i++) begin
            chk_outs("halt", 0, 0, 0, 0, 0, 1);
            mem_gnt = 1'($urandom_range(0, 1));
            mem_rvalid = 1'($urandom_range(0, 1));
            step();
         end
         chk("halt_instret", instret, exp_instret);
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         return;
      end
      if (kind == K_LOAD || kind == K_STORE) begin
         for (int i = 0; i <= gd; i++) begin
            chk_outs("mem_req", 1, 1, is_st, 0, 0, 0);
            mem_gnt = (i == gd);
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata = $urandom();
            step();
         end
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end
      if (kind == K_LOAD) begin
         for (int i = 1; i <= rd; i++) begin
            chk_outs("mem_wait", 0, 0, 0, 0, 0, 0);
            mem_rvalid = (i == rd);
            mem_rdata = (i == rd) ? ddata : $urandom();
            step();
         end
         mem_rvalid = 1'b0;
         exp_mdr = ddata;
      end
      chk_state("wb_state", S_WB);
      chk_outs("wb", 0, 0, 0, 1, regwen, 0);
      chk("mdr", mdr, exp_mdr);
      step();
      exp_instret = exp_instret + 32'd1;
      chk("instret", instret, exp_instret);
      halt_req = 1'b0;
   endtask

   initial begin
      do_reset();
      step();
      chk_state("if_req_cycle1", S_IF_REQ);

      // addi, zero-wait: WB on cycle 4, register written
      run_instr(K_ALU, 0, 1, 0, 1, 32'd0, 2'b00, 1);
      // load with delayed grant and data
      run_instr(K_LOAD, 0, 1, 3, 2, 32'hDEAD_BEEF, 2'b00, 1);
      chk("lw_mdr", mdr, 32'hDEAD_BEEF);
      // zero-wait store
      run_instr(K_STORE, 0, 1, 0, 1, 32'd0, 2'b00, 0);
      // retire count wraps
      dut.u_instret.count = 32'hFFFF_FFFF;
      exp_instret = 32'hFFFF_FFFF;
      run_instr(K_ALU, 1, 2, 0, 1, 32'd0, 2'b00, 2);
      chk("instret_wrap", instret, 32'd0);

      for (int n = 0; n < 30; n++) begin
         run_instr($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 3),
                   $urandom_range(0, 3), $urandom_range(1, 3), $urandom(), 2'b00, 2);
      end

      // reset in the middle of a fetch; stale rvalid must not reach ir
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      rst = 1'b1;
      step();
      chk_state("mid_rst_state", S_IDLE);
      chk_outs("mid_rst_strobes", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      step();
      chk("stale_ir_0", ir, 32'd0);
      step();
      chk("stale_ir_1", ir, 32'd0);
      chk_state("stale_state", S_IF_REQ);
      mem_rvalid = 1'b0;
      exp_instret = 32'd0;
      exp_mdr = 32'd0;
      run_instr(K_LOAD, 0, 1, 0, 1, 32'h1234_5678, 2'b00, 1);

      // ebreak: absorbing halt, then reset back to IDLE
      run_instr(K_HALT, 0, 1, 0, 1, 32'd0, 2'b00, 0);
      chk_state("halt_state", S_HALT);
      do_reset();

`ifdef MISALIGN_CHECK_EN
      step();
      run_instr(K_LOAD, 0, 1, 0, 1, 32'd0, 2'b10, 1);
      chk_state("misal_lw_state", S_HALT);
      do_reset();
      pc_lo = 2'b01;
      step();
      chk_outs("misal_pc_req", 0, 0, 0, 0, 0, 0);
      step();
      chk_outs("misal_pc_halt", 0, 0, 0, 0, 0, 1);
      chk_state("misal_pc_state", S_HALT);
      do_reset();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
